// File: rtl/bus_mem_slave.sv
// bus_mem_slave: memory target for the req/gnt/start/rdy processor bus.
//
// The master raises req and is granted the bus. A start sampled while
// granted latches mode and addr. After WAIT_CYCLES wait states the slave
// completes one beat per cycle, pulsing rdy. A burst completes BURST_LEN
// beats; a single transfer completes one. Addresses wrap from DEPTH-1 to 0.
// A start address at or above DEPTH gives one error beat with no write.
// Storage is a flop array that reset does not clear.
//
// Ports:
//   clk    in   bus clock, rising edge
//   rst    in   synchronous reset, active-high
//   req    in   master requests the bus
//   start  in   begin transaction (sampled only while gnt=1)
//   mode   in   00 rd, 01 wr, 10 burst rd, 11 burst wr
//   addr   in   start address, sampled with start
//   wdata  in   write data, sampled on each write beat
//   gnt    out  bus granted
//   rdy    out  beat complete, one cycle per beat
//   rdata  out  read data while rdy on a read, else 0
//   err    out  out-of-range access, only together with rdy
module bus_mem_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int BURST_LEN   = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              gnt,
    output logic              rdy,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int BCW  = $clog2(BURST_LEN + 1);
    localparam int WCW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]   DEPTH_X     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [BCW-1:0]    BURST_BEATS = BCW'(BURST_LEN);
    localparam logic [BCW-1:0]    ONE_BEAT    = BCW'(1);
    localparam logic [WCW-1:0]    WAIT_LOAD   = WCW'(WAIT_CYCLES);
    localparam logic [WCW-1:0]    WAIT_ONE    = WCW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_XFER  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [BCW-1:0]     beats;
    logic [WCW-1:0]     wait_cnt;
    logic [ADDR_W-1:0]  cur_addr;
    logic               is_write;
    logic               in_range;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept;
    logic               addr_ok;
    logic               wr_en;
    logic [IDXW-1:0]    idx;

    assign accept  = (state == S_GRANT) && start;
    assign addr_ok = ({1'b0, addr} < DEPTH_X);
    assign idx     = cur_addr[IDXW-1:0];
    // A beat cut short by reset must not reach the array.
    assign wr_en   = (state == S_XFER) && is_write && in_range && !rst;

    // State and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            beats    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // An out-of-range start always collapses to a single beat.
                beats    <= (mode[1] && addr_ok) ? BURST_BEATS : ONE_BEAT;
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_XFER) begin
                beats <= beats - ONE_BEAT;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - WAIT_ONE;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req) state_nx = S_GRANT;
            end
            S_GRANT: begin
                if (start)     state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_XFER;
                else if (!req) state_nx = S_IDLE;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_ONE) state_nx = S_XFER;
            end
            S_XFER: begin
                if (beats == ONE_BEAT) state_nx = req ? S_GRANT : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Latched transaction, address walk and storage
    always_ff @(posedge clk) begin
        if (accept) begin
            cur_addr <= addr;
            is_write <= mode[0];
            in_range <= addr_ok;
        end else if (state == S_XFER) begin
            cur_addr <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
        end
        if (wr_en) mem[idx] <= wdata;
    end

    // Bus outputs; held at zero while reset is asserted
    always_comb begin
        gnt   = 1'b0;
        rdy   = 1'b0;
        err   = 1'b0;
        rdata = '0;
        if (!rst) begin
            case (state)
                S_GRANT: gnt = 1'b1;
                S_XFER: begin
                    rdy = 1'b1;
                    err = !in_range;
                    if (in_range && !is_write) rdata = mem[idx];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_slave.sv
module tb_bus_mem_slave;

    logic       clk = 1'b0;
    logic       rst, req, start;
    logic [1:0] mode;
    logic [7:0] addr, wdata;
    int         sel;

    logic       req0, req1, req2, st0, st1, st2;
    logic       gnt0, gnt1, gnt2, rdy0, rdy1, rdy2, err0, err1, err2;
    logic [7:0] rd0, rd1, rd2;
    logic       gnt_m, rdy_m, err_m;
    logic [7:0] rdata_m;

    int n_cmp = 0;
    int n_fail = 0;

    // transaction record filled by run_txn
    logic [7:0] wq [8];
    logic [7:0] rq [8];
    logic       eq [8];
    int         nb, lat;
    bit         gap, post_gnt, post_rdy;

    always #5 clk = ~clk;

    assign req0 = req && (sel == 0);
    assign req1 = req && (sel == 1);
    assign req2 = req && (sel == 2);
    assign st0  = start && (sel == 0);
    assign st1  = start && (sel == 1);
    assign st2  = start && (sel == 2);

    always_comb begin
        case (sel)
            1:       begin gnt_m = gnt1; rdy_m = rdy1; err_m = err1; rdata_m = rd1; end
            2:       begin gnt_m = gnt2; rdy_m = rdy2; err_m = err2; rdata_m = rd2; end
            default: begin gnt_m = gnt0; rdy_m = rdy0; err_m = err0; rdata_m = rd0; end
        endcase
    end

    bus_mem_slave u_def (
        .clk(clk), .rst(rst), .req(req0), .start(st0), .mode(mode), .addr(addr),
        .wdata(wdata), .gnt(gnt0), .rdy(rdy0), .rdata(rd0), .err(err0)
    );

    bus_mem_slave #(.DEPTH(200)) u_d200 (
        .clk(clk), .rst(rst), .req(req1), .start(st1), .mode(mode), .addr(addr),
        .wdata(wdata), .gnt(gnt1), .rdy(rdy1), .rdata(rd1), .err(err1)
    );

    bus_mem_slave #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req2), .start(st2), .mode(mode), .addr(addr),
        .wdata(wdata), .gnt(gnt2), .rdy(rdy2), .rdata(rd2), .err(err2)
    );

    // Requests the bus, issues one transaction and records every beat.
    // hold_start keeps start high after acceptance with a different mode/addr.
    task automatic run_txn(input logic [1:0] m, input logic [7:0] a, input int exp_beats,
                           input bit keep_req, input bit hold_start);
        int c;
        int last;
        nb = 0; lat = -1; gap = 0; post_gnt = 0; post_rdy = 0;
        for (int i = 0; i < 8; i++) begin rq[i] = 8'h00; eq[i] = 1'b0; end
        req = 1'b1;
        c = 0;
        @(negedge clk);
        while (gnt_m !== 1'b1 && c < 8) begin @(negedge clk); c++; end
        if (gnt_m !== 1'b1) begin req = 1'b0; return; end
        start = 1'b1; mode = m; addr = a; wdata = wq[0];
        @(posedge clk); #1;
        if (hold_start) begin mode = m ^ 2'b01; addr = a + 8'd1; end
        else start = 1'b0;
        req = keep_req;
        c = 1; last = 0;
        while (nb < exp_beats && c <= 12) begin
            wdata = wq[nb];
            @(negedge clk);
            if (rdy_m === 1'b1) begin
                rq[nb] = rdata_m; eq[nb] = err_m;
                if (nb == 0) lat = c;
                else if (c != last + 1) gap = 1;
                last = c; nb++;
            end
            @(posedge clk); #1; c++;
        end
        @(negedge clk);
        post_gnt = gnt_m; post_rdy = rdy_m;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b1; start = 1'b1; mode = 2'b01; addr = 8'h00; wdata = 8'h00;
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt_m, rdy_m, err_m, rdata_m} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: gnt/rdy/err/rdata = %b/%b/%b/%h, need all 0",
                         i, gnt_m, rdy_m, err_m, rdata_m);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (gnt_m !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: gnt=%b need 0", gnt_m); end
        @(negedge clk);
        n_cmp++;
        if (gnt_m !== 1'b1) begin n_fail++; $display("FAIL reset_release_gnt: gnt=%b need 1", gnt_m); end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        sel = 0;
        wq[0] = 8'hA5;
        run_txn(2'b01, 8'h10, 1, 1'b0, 1'b0);
        n_cmp++;
        if (nb !== 1 || lat !== 2) begin
            n_fail++; $display("FAIL single_wr_timing: beats=%0d lat=%0d need 1/2", nb, lat);
        end
        n_cmp++;
        if (eq[0] !== 1'b0 || post_rdy !== 1'b0) begin
            n_fail++; $display("FAIL single_wr_flags: err=%b post_rdy=%b need 0/0", eq[0], post_rdy);
        end
        run_txn(2'b00, 8'h10, 1, 1'b0, 1'b0);
        n_cmp++;
        if (rq[0] !== 8'hA5 || eq[0] !== 1'b0) begin
            n_fail++; $display("FAIL single_rd_data: rdata=%h err=%b need a5/0", rq[0], eq[0]);
        end
        n_cmp++;
        if (nb !== 1 || lat !== 2 || post_rdy !== 1'b0 || post_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rd_shape: beats=%0d lat=%0d post_rdy=%b post_gnt=%b need 1/2/0/0",
                     nb, lat, post_rdy, post_gnt);
        end
    endtask

    task automatic test_burst_wrap;
        sel = 0;
        wq[0] = 8'h01; wq[1] = 8'h02; wq[2] = 8'h03; wq[3] = 8'h04;
        run_txn(2'b11, 8'hFE, 4, 1'b0, 1'b0);
        n_cmp++;
        if (nb !== 4 || gap !== 1'b0 || post_rdy !== 1'b0) begin
            n_fail++; $display("FAIL burst_wr_shape: beats=%0d gap=%b post_rdy=%b need 4/0/0", nb, gap, post_rdy);
        end
        run_txn(2'b10, 8'hFE, 4, 1'b0, 1'b0);
        n_cmp++;
        if ({rq[0], rq[1], rq[2], rq[3]} !== 32'h01020304) begin
            n_fail++; $display("FAIL burst_rd_data: got %h %h %h %h need 01 02 03 04", rq[0], rq[1], rq[2], rq[3]);
        end
        n_cmp++;
        if (nb !== 4 || gap !== 1'b0 || lat !== 2 || {eq[0], eq[1], eq[2], eq[3]} !== 4'b0000) begin
            n_fail++; $display("FAIL burst_rd_shape: beats=%0d gap=%b lat=%0d errs=%b%b%b%b need 4/0/2/0000",
                               nb, gap, lat, eq[0], eq[1], eq[2], eq[3]);
        end
    endtask

    task automatic test_depth200;
        sel = 1;
        run_txn(2'b00, 8'hC8, 1, 1'b0, 1'b0);
        n_cmp++;
        if (nb !== 1 || eq[0] !== 1'b1 || rq[0] !== 8'h00 || post_rdy !== 1'b0) begin
            n_fail++; $display("FAIL oor_read: beats=%0d err=%b rdata=%h post_rdy=%b need 1/1/00/0",
                               nb, eq[0], rq[0], post_rdy);
        end
        wq[0] = 8'h77;
        run_txn(2'b01, 8'h08, 1, 1'b0, 1'b0);
        wq[0] = 8'h55;
        run_txn(2'b11, 8'hD0, 1, 1'b0, 1'b0);
        n_cmp++;
        if (nb !== 1 || eq[0] !== 1'b1 || post_rdy !== 1'b0) begin
            n_fail++; $display("FAIL oor_write: beats=%0d err=%b post_rdy=%b need 1/1/0", nb, eq[0], post_rdy);
        end
        run_txn(2'b00, 8'h08, 1, 1'b0, 1'b0);
        n_cmp++;
        if (rq[0] !== 8'h77 || eq[0] !== 1'b0) begin
            n_fail++; $display("FAIL oor_no_alias: mem[08]=%h err=%b need 77/0", rq[0], eq[0]);
        end
        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33; wq[3] = 8'h44;
        run_txn(2'b11, 8'hC6, 4, 1'b0, 1'b0);
        run_txn(2'b10, 8'hC6, 4, 1'b0, 1'b0);
        n_cmp++;
        if ({rq[0], rq[1], rq[2], rq[3]} !== 32'h11223344 || {eq[0], eq[1], eq[2], eq[3]} !== 4'b0000) begin
            n_fail++; $display("FAIL d200_burst_rd: got %h %h %h %h errs=%b%b%b%b need 11 22 33 44 / 0000",
                               rq[0], rq[1], rq[2], rq[3], eq[0], eq[1], eq[2], eq[3]);
        end
        run_txn(2'b00, 8'h00, 1, 1'b0, 1'b0);
        n_cmp++;
        if (rq[0] !== 8'h33 || eq[0] !== 1'b0) begin
            n_fail++; $display("FAIL d200_wrap_to_zero: mem[00]=%h err=%b need 33/0", rq[0], eq[0]);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        sel = 0;
        wq[0] = 8'hE0; wq[1] = 8'hE1; wq[2] = 8'hE2; wq[3] = 8'hE3;
        run_txn(2'b11, 8'h20, 4, 1'b0, 1'b0);
        req = 1'b1; c = 0;
        @(negedge clk);
        while (gnt_m !== 1'b1 && c < 8) begin @(negedge clk); c++; end
        start = 1'b1; mode = 2'b11; addr = 8'h20; wdata = 8'h91;
        @(posedge clk); #1;
        start = 1'b0; req = 1'b0;
        c = 0;
        @(negedge clk);
        while (rdy_m !== 1'b1 && c < 8) begin @(negedge clk); c++; end
        n_cmp++;
        if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_beat: rdy=%b need 1", rdy_m); end
        @(posedge clk); #1;
        wdata = 8'h92; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (gnt_m !== 1'b0 || rdy_m !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after: gnt=%b rdy=%b need 0/0", gnt_m, rdy_m);
        end
        run_txn(2'b10, 8'h20, 4, 1'b0, 1'b0);
        n_cmp++;
        if ({rq[0], rq[1], rq[2], rq[3]} !== 32'h91E1E2E3) begin
            n_fail++; $display("FAIL rstmid_mem: got %h %h %h %h need 91 e1 e2 e3", rq[0], rq[1], rq[2], rq[3]);
        end
    endtask

    task automatic test_handshake;
        int c;
        sel = 0;
        // req dropped while granted, no start
        req = 1'b1; c = 0;
        @(negedge clk);
        while (gnt_m !== 1'b1 && c < 8) begin @(negedge clk); c++; end
        n_cmp++;
        if (gnt_m !== 1'b1) begin n_fail++; $display("FAIL hs_grant: gnt=%b need 1", gnt_m); end
        req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (gnt_m !== 1'b0 || rdy_m !== 1'b0) begin
            n_fail++; $display("FAIL hs_grant_drop: gnt=%b rdy=%b need 0/0", gnt_m, rdy_m);
        end
        // start pulsed in IDLE
        wq[0] = 8'h3C;
        run_txn(2'b01, 8'h30, 1, 1'b0, 1'b0);
        start = 1'b1; mode = 2'b01; addr = 8'h30; wdata = 8'hCC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (gnt_m !== 1'b0 || rdy_m !== 1'b0) begin
                n_fail++; $display("FAIL hs_idle_start cyc%0d: gnt=%b rdy=%b need 0/0", i, gnt_m, rdy_m);
            end
        end
        start = 1'b0;
        // start held through WAIT and XFER with a write mode
        wq[0] = 8'hCC;
        run_txn(2'b00, 8'h30, 1, 1'b0, 1'b1);
        n_cmp++;
        if (nb !== 1 || rq[0] !== 8'h3C || post_rdy !== 1'b0) begin
            n_fail++; $display("FAIL hs_wait_start: beats=%0d rdata=%h post_rdy=%b need 1/3c/0", nb, rq[0], post_rdy);
        end
        run_txn(2'b00, 8'h31, 1, 1'b0, 1'b0);
        wq[0] = 8'h00;
        run_txn(2'b00, 8'h30, 1, 1'b0, 1'b0);
        n_cmp++;
        if (rq[0] !== 8'h3C) begin n_fail++; $display("FAIL hs_no_stray_write: mem[30]=%h need 3c", rq[0]); end
    endtask

    task automatic test_back_to_back;
        sel = 0;
        wq[0] = 8'h4B;
        run_txn(2'b01, 8'h40, 1, 1'b1, 1'b0);
        n_cmp++;
        if (post_gnt !== 1'b1 || post_rdy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_regrant: post_gnt=%b post_rdy=%b need 1/0", post_gnt, post_rdy);
        end
        run_txn(2'b00, 8'h40, 1, 1'b0, 1'b0);
        n_cmp++;
        if (rq[0] !== 8'h4B || lat !== 2 || post_gnt !== 1'b0) begin
            n_fail++; $display("FAIL b2b_read: rdata=%h lat=%0d post_gnt=%b need 4b/2/0", rq[0], lat, post_gnt);
        end
    endtask

    task automatic test_no_wait;
        sel = 2;
        wq[0] = 8'h5A; wq[1] = 8'h5B; wq[2] = 8'h5C; wq[3] = 8'h5D;
        run_txn(2'b11, 8'h05, 4, 1'b0, 1'b0);
        n_cmp++;
        if (nb !== 4 || lat !== 1 || gap !== 1'b0) begin
            n_fail++; $display("FAIL w0_burst_wr: beats=%0d lat=%0d gap=%b need 4/1/0", nb, lat, gap);
        end
        run_txn(2'b00, 8'h07, 1, 1'b0, 1'b0);
        n_cmp++;
        if (rq[0] !== 8'h5C || lat !== 1 || eq[0] !== 1'b0) begin
            n_fail++; $display("FAIL w0_single_rd: rdata=%h lat=%0d err=%b need 5c/1/0", rq[0], lat, eq[0]);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst_wrap;
        test_depth200;
        test_reset_mid;
        test_handshake;
        test_back_to_back;
        test_no_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Parametrised memory target for the shared req/gnt/start/rdy processor bus; next generation of the bus memory endpoint.
- Adds configurable data and address widths, depth, programmable wait states, burst transfers with address wrap, and out-of-range error signalling.
- Sits on the bus opposite the CPU core.
- Storage is a flop array. It is not cleared by reset.

Parameters:
- DATA_W, 8: data bus width.
- ADDR_W, 8: address bus width.
- DEPTH, 256: number of words. Must satisfy 1 <= DEPTH <= 2**ADDR_W.
- BURST_LEN, 4: number of beats in a burst mode. Must be >= 1.
- WAIT_CYCLES, 1: wait states between start acceptance and the first beat. Must be >= 0.

Ports:
- clk, input, 1: bus clock. All logic is on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- req, input, 1: master requests the bus.
- start, input, 1: master begins a transaction. Sampled only while gnt=1.
- mode, input, 2: 00 single read, 01 single write, 10 burst read, 11 burst write.
- addr, input, ADDR_W: start address, sampled with start.
- wdata, input, DATA_W: write data, sampled on each write beat.
- gnt, output, 1: bus granted.
- rdy, output, 1: beat complete, high for one cycle per beat.
- rdata, output, DATA_W: read data, valid while rdy=1 on a read, otherwise 0.
- err, output, 1: out-of-range access, high together with rdy.

Behaviour:
- Reset:
  - Outputs: gnt=0, rdy=0, err=0, rdata=0.
  - Internal: FSM goes to IDLE; beat and wait counters are cleared.
  - Reset during any state aborts the transaction. Beats already written stay in memory; no further beats are written.
- IDLE:
  - gnt=0.
  - req=1 -> GRANT next cycle.
  - start is ignored.
- GRANT:
  - gnt=1.
  - start=1 -> latch mode and addr; set beats = 1 (single) or BURST_LEN (burst).
  - Next state is WAIT if WAIT_CYCLES>0, else XFER.
  - start=0 and req=0 -> IDLE (gnt=0 next cycle).
  - start=0 and req=1 -> stay in GRANT.
- WAIT:
  - gnt=0.
  - Counts WAIT_CYCLES cycles, then goes to XFER.
  - req and start are ignored.
- XFER:
  - gnt=0. Each cycle completes one beat: rdy=1.
  - Read beat: rdata = mem[cur_addr].
  - Write beat: mem[cur_addr] <= wdata at the closing edge of the beat.
  - cur_addr increments after each beat. The value after DEPTH-1 is 0 (wrap).
  - After the last beat: req=1 -> GRANT, req=0 -> IDLE.
  - Dropping req mid-transaction does not shorten it.
- Latency:
  - With start sampled at the edge ending cycle N, the first rdy occurs in cycle N+1+WAIT_CYCLES.
  - Burst beats occur on consecutive cycles with no gaps.
- Out of range (only possible when DEPTH < 2**ADDR_W):
  - A latched start addr >= DEPTH produces exactly one XFER cycle regardless of mode: rdy=1, err=1, rdata=0.
  - No memory write occurs.
  - A burst that starts in range never raises err; it wraps within 0..DEPTH-1.
- Counters: the beat counter is sized clog2(BURST_LEN+1); the wait counter is sized clog2(WAIT_CYCLES+1), minimum 1 bit.
- err=0 and rdata=0 whenever rdy=0.
- Exactly one transaction is in flight at a time.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with req=1 and start=1 -> gnt=0, rdy=0, err=0, rdata=0 throughout. Release -> gnt=1 one cycle later.
2. Single write then single read (defaults):
   - Write addr 0x10, wdata 0xA5, start sampled at cycle N -> single rdy at N+2.
   - Read addr 0x10 -> rdy with rdata=0xA5, err=0, for exactly one cycle.
3. Burst wrap (defaults):
   - Burst write at 0xFE with wdata 0x01, 0x02, 0x03, 0x04 on 4 consecutive rdy cycles -> mem[0xFE]=1, mem[0xFF]=2, mem[0x00]=3, mem[0x01]=4.
   - Burst read at 0xFE -> rdata 1, 2, 3, 4 on 4 back-to-back rdy cycles.
4. DEPTH=200 instance:
   - Read 0xC8 -> one rdy cycle with err=1, rdata=0.
   - Write 0xD0 with 0x55 -> err=1 and no array change.
   - Burst read from 0xC6 -> addresses 0xC6, 0xC7, 0x00, 0x01, with err=0 on all beats.
5. Reset mid-burst: burst write at 0x20 with rst asserted during beat 2 -> mem[0x20] written; mem[0x21..0x23] unchanged; next cycle gnt=0, rdy=0.
6. Handshake edges:
   - req dropped in GRANT without start -> gnt=0 next cycle.
   - start pulsed while in IDLE or WAIT -> ignored.
   - req held through a transaction end -> gnt=1 the cycle after the last rdy.
   - WAIT_CYCLES=0 instance -> rdy in cycle N+1.
